// File: rtl/id_hazard_scoreboard.sv
// Decode-stage issue controller: tracks in-flight register writes per architectural
// register, blocks issue on RAW / WAW-saturation / budget hazards, and sequences a drain.
module id_hazard_scoreboard #(
  parameter int MAX_OUT = 8,
  parameter int CW      = 2,
  parameter int OW      = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_id_valid,
  input  logic [4:0]    i_rs1,
  input  logic [4:0]    i_rs2,
  input  logic          i_use_rs1,
  input  logic          i_use_rs2,
  input  logic [4:0]    i_rd,
  input  logic          i_RegWrite,
  input  logic          i_ex_ready,
  input  logic          i_wb_valid,
  input  logic [4:0]    i_wb_rd,
  input  logic          i_drain,
  output logic          o_issue,
  output logic          o_stall,
  output logic          o_busy,
  output logic [OW-1:0] o_outstanding,
  output logic          o_drained,
  output logic          o_wb_err,
  output logic [31:0]   o_stall_cnt
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUT);

  logic [CW-1:0] cnt_q [32];
  logic [OW-1:0] outstanding_q, outstanding_d;
  logic [1:0]    state_q, state_d;
  logic          wb_err_q;
  logic [31:0]   stall_cnt_q;

  logic [CW-1:0] cnt_rs1, cnt_rs2, cnt_rd, cnt_wb;
  logic          raw, waw_full, budget_full;
  logic          inc, dec, wb_bad;

  // Hazards look only at registered counts; a same-cycle retirement frees the
  // register one cycle later.
  assign cnt_rs1 = cnt_q[i_rs1];
  assign cnt_rs2 = cnt_q[i_rs2];
  assign cnt_rd  = cnt_q[i_rd];
  assign cnt_wb  = cnt_q[i_wb_rd];

  assign raw = (i_use_rs1 && (i_rs1 != 5'd0) && (cnt_rs1 != '0)) ||
               (i_use_rs2 && (i_rs2 != 5'd0) && (cnt_rs2 != '0));
  assign waw_full    = i_RegWrite && (i_rd != 5'd0) && (cnt_rd == CNT_MAX);
  assign budget_full = (outstanding_q == OUT_MAX);

  assign o_issue = i_id_valid && i_ex_ready && (state_q == ST_RUN) && !i_drain &&
                   !raw && !waw_full && !budget_full;
  assign o_stall = i_id_valid && !o_issue;

  assign inc    = o_issue && i_RegWrite && (i_rd != 5'd0);
  assign dec    = i_wb_valid && (i_wb_rd != 5'd0) && (cnt_wb != '0);
  assign wb_bad = i_wb_valid && (i_wb_rd != 5'd0) && (cnt_wb == '0);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (i_drain) state_d = ST_DRAIN;
      ST_DRAIN: if (outstanding_q == '0) state_d = ST_HALT;
      ST_HALT:  if (!i_drain) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_comb begin
    outstanding_d = outstanding_q;
    if (inc && !dec)      outstanding_d = outstanding_q + OW'(1);
    else if (dec && !inc) outstanding_d = outstanding_q - OW'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (i_rst) begin
      state_q       <= ST_RUN;
      outstanding_q <= '0;
      wb_err_q      <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      if (wb_bad) wb_err_q <= 1'b1;
      if (o_stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: the count array is reset because the hazard logic reads it on the first cycle.
    if (i_rst) begin
      for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
    end else begin
      // Entry 0 keeps its reset value: x0 writes are never tracked.
      for (int r = 1; r < 32; r++) begin
        if (inc && (i_rd == 5'(r)) && !(dec && (i_wb_rd == 5'(r))))
          cnt_q[r] <= cnt_q[r] + CW'(1);
        else if (dec && (i_wb_rd == 5'(r)) && !(inc && (i_rd == 5'(r))))
          cnt_q[r] <= cnt_q[r] - CW'(1);
      end
    end
  end

  assign o_busy        = (outstanding_q != '0);
  assign o_outstanding = outstanding_q;
  assign o_drained     = (state_q == ST_HALT);
  assign o_wb_err      = wb_err_q;
  assign o_stall_cnt   = stall_cnt_q;

endmodule
